// File: rtl/sram22_1024x32_arb.sv
// Two-requester round-robin arbiter in front of a single-port SRAM22 macro (1-cycle read latency).
// Optional power-up clear of the whole macro is enabled by defining SRAM22_ARB_INIT_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_INIT | clearing the macro, one word per cycle; requests held off
// ST_RUN  | arbitrating requesters onto the macro port
module sram22_1024x32_arb #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    sram_we,
    output logic                    sram_wmask,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_din,
    input  logic [DATA_WIDTH-1:0]   sram_dout,
    output logic                    init_done
);

    logic       run;
    logic       prio;
    logic [1:0] grant;

`ifdef SRAM22_ARB_INIT_EN
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   init_cnt, init_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        if (state == ST_INIT) begin
            init_cnt_nxt = init_cnt + 1'b1;
            if (init_cnt == '1)
                state_nxt = ST_RUN;
        end
    end

    assign run = (state == ST_RUN);
`else
    assign run = 1'b1;
`endif

    assign init_done = run;

    // prio names the requester that wins when both are valid
    always_comb begin
        grant = 2'b00;
        if (run) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;

    always_comb begin
        sram_we    = 1'b0;
        sram_wmask = 1'b0;
        sram_addr  = '0;
        sram_din   = '0;
`ifdef SRAM22_ARB_INIT_EN
        if (!run) begin
            sram_we    = 1'b1;
            sram_wmask = 1'b1;
            sram_addr  = init_cnt;
        end else
`endif
        if (grant != 2'b00) begin
            sram_wmask = 1'b1;
            sram_we    = grant[1] ? req_we[1] : req_we[0];
            sram_addr  = grant[1] ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                  : req_addr[0 +: ADDR_WIDTH];
            sram_din   = grant[1] ? req_wdata[DATA_WIDTH +: DATA_WIDTH]
                                  : req_wdata[0 +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio      <= 1'b0;
            rsp_valid <= 2'b00;
        end else begin
            if (grant != 2'b00)
                prio <= grant[0];
            rsp_valid <= grant & ~req_we;
        end
    end

    assign rsp_rdata = (rsp_valid != 2'b00) ? sram_dout : '0;

endmodule

// File: tb/tb_sram22_1024x32_arb.sv
// Bench for sram22_1024x32_arb: vector table plus reset/round-robin sequences, with a
// behavioural macro model and a response scoreboard. Handles SRAM22_ARB_INIT_EN either way.
module tb_sram22_1024x32_arb;

    localparam int AW = 10;
    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            sram_we;
    logic            sram_wmask;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_din;
    logic [DW-1:0]   sram_dout;
    logic            init_done;

    sram22_1024x32_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout), .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural macro: registered read, masked write
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    function automatic logic [DW-1:0] pat(input int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0001);
    endfunction

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            mem[i]     = pat(i);
            ref_mem[i] = pat(i);
        end
        sram_dout = '0;
    end

    always @(posedge clk) begin
        if (sram_wmask) begin
            if (sram_we) mem[sram_addr] <= sram_din;
            else         sram_dout      <= mem[sram_addr];
        end
    end

    typedef struct {
        logic [1:0]    valid;
        logic [1:0]    we;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [1:0]    ready;
    } vec_t;

    typedef struct {
        int            due;
        logic          id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

`ifdef SRAM22_ARB_INIT_EN
    localparam logic INIT_IN_RESET = 1'b0;
`else
    localparam logic INIT_IN_RESET = 1'b1;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [1:0] v, input logic [1:0] w,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                 input logic [1:0] r);
        vec_t t;
        t.valid = v; t.we = w; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1; t.ready = r;
        return t;
    endfunction

    task automatic step(input vec_t v);
        exp_t          e;
        logic [1:0]    exp_rv;
        logic [DW-1:0] exp_rd;
        logic          sel;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
        @(negedge clk);
        req_valid = v.valid;
        req_we    = v.we;
        req_addr  = {v.a1, v.a0};
        req_wdata = {v.d1, v.d0};
        #1;
        exp_rv = 2'b00;
        exp_rd = '0;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e      = sbq.pop_front();
            exp_rv = e.id ? 2'b10 : 2'b01;
            exp_rd = e.data;
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        chk("req_ready", 64'(req_ready), 64'(v.ready));
        chk("init_done", 64'(init_done), 64'(1'b1));
        if (v.ready != 2'b00) begin
            sel = v.ready[1];
            a   = sel ? v.a1 : v.a0;
            d   = sel ? v.d1 : v.d0;
            w   = v.we[sel];
            chk("sram_addr",  64'(sram_addr),  64'(a));
            chk("sram_din",   64'(sram_din),   64'(d));
            chk("sram_we",    64'(sram_we),    64'(w));
            chk("sram_wmask", 64'(sram_wmask), 64'(1'b1));
            if (!w) begin
                e.due = cyc + 1; e.id = sel; e.data = ref_mem[a];
                sbq.push_back(e);
            end else begin
                ref_mem[a] = d;
            end
        end else begin
            chk("idle_sram_we",    64'(sram_we),    64'(1'b0));
            chk("idle_sram_wmask", 64'(sram_wmask), 64'(1'b0));
            chk("idle_sram_addr",  64'(sram_addr),  64'(0));
            chk("idle_sram_din",   64'(sram_din),   64'(0));
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_init_done", 64'(init_done), 64'(INIT_IN_RESET));
        sbq.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
`ifdef SRAM22_ARB_INIT_EN
        // hold a read from requester 0 through the clear; it must be granted on the first RUN cycle
        for (int i = 0; i < (1<<AW); i++) begin
            @(negedge clk);
            req_valid = 2'b01;
            req_we    = 2'b00;
            req_addr  = '0;
            #1;
            chk("init_done_low", 64'(init_done),  64'(1'b0));
            chk("init_we",       64'(sram_we),    64'(1'b1));
            chk("init_wmask",    64'(sram_wmask), 64'(1'b1));
            chk("init_addr",     64'(sram_addr),  64'(i));
            chk("init_din",      64'(sram_din),   64'(0));
            chk("init_ready",    64'(req_ready),  64'(0));
        end
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
`endif
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = mkv(2'b01, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b01);
        vecs[1]  = mkv(2'b01, 2'b01, 10'h155, 10'h000, 32'hDEADBEEF, 32'h0,        2'b01);
        vecs[2]  = mkv(2'b10, 2'b00, 10'h000, 10'h155, 32'h0,        32'h0,        2'b10);
        vecs[3]  = mkv(2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b00);
        vecs[4]  = mkv(2'b10, 2'b00, 10'h000, 10'h3FF, 32'h0,        32'h0,        2'b10);
        vecs[5]  = mkv(2'b10, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b10);
        vecs[6]  = mkv(2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b00);
        vecs[7]  = mkv(2'b01, 2'b01, 10'h3FF, 10'h000, 32'h12345678, 32'h0,        2'b01);
        vecs[8]  = mkv(2'b11, 2'b00, 10'h3FF, 10'h001, 32'h0,        32'h11110000, 2'b10);
        vecs[9]  = mkv(2'b11, 2'b01, 10'h002, 10'h3FF, 32'hCAFEF00D, 32'h0,        2'b01);
        vecs[10] = mkv(2'b11, 2'b00, 10'h002, 10'h3FF, 32'h0,        32'h0,        2'b10);
        vecs[11] = mkv(2'b01, 2'b00, 10'h002, 10'h000, 32'h0,        32'h0,        2'b01);
        vecs[12] = mkv(2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b00);
        vecs[13] = mkv(2'b10, 2'b10, 10'h000, 10'h004, 32'h0,        32'h0BADF00D, 2'b10);
        vecs[14] = mkv(2'b01, 2'b00, 10'h004, 10'h000, 32'h0,        32'h0,        2'b01);
        vecs[15] = mkv(2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b00);

        rst_n     = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        do_reset();

        for (int i = 0; i < 16; i++) step(vecs[i]);

        // single read by requester 0 leaves the pointer favouring requester 1, then reset hits
        step(mkv(2'b01, 2'b00, 10'h010, 10'h000, 32'h0, 32'h0, 2'b01));
        do_reset();

        // pointer must be back on requester 0, then strict alternation under contention
        for (int i = 0; i < 8; i++)
            step(mkv(2'b11, 2'b00, 10'(i), 10'(10'h3F0 + i), 32'h0, 32'h0,
                     (i % 2 == 0) ? 2'b01 : 2'b10));
        step(mkv(2'b00, 2'b00, 10'h000, 10'h000, 32'h0, 32'h0, 2'b00));
        step(mkv(2'b00, 2'b00, 10'h000, 10'h000, 32'h0, 32'h0, 2'b00));

        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
